// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode encodings.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timerState_t;

   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] PRESET_OFF = 2'd1;
   localparam logic [1:0] COUNT_OFF  = 2'd2;

   localparam int EN_BIT   = 0;
   localparam int MODE_LSB = 1;
   localparam int IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer responding to M-stage loads/stores. CTRL/PRESET are
// CPU-writable, COUNT is read-only, and irq is the latched flag gated by IM.
// CPU writes are applied after the FSM update so they win any same-edge
// conflict (e.g. the FSM clearing EN in one-shot INT).
module timer_counter
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic        r_en;
   logic [1:0]  r_mode;
   logic        r_im;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_irqFlag;
   timerState_t r_state;

   logic [1:0]  w_offset;
   logic        w_write;
   logic        w_ctrlWr;
   logic        w_presetWr;
   logic [31:0] w_ctrlRead;
   logic        w_unusedAddr;

   assign w_offset     = addr[3:2];
   assign w_write      = sel & we;
   assign w_ctrlWr     = w_write && (w_offset == CTRL_OFF);
   assign w_presetWr   = w_write && (w_offset == PRESET_OFF);
   assign w_ctrlRead   = {28'd0, r_im, r_mode, r_en};
   assign w_unusedAddr = ^{addr[31:4], addr[1:0]};

   // Read mux: combinational so loads complete in the same M-stage cycle.
   always_comb begin
      rdata = 32'd0;
      case (w_offset)
         CTRL_OFF:   rdata = w_ctrlRead;
         PRESET_OFF: rdata = r_preset;
         COUNT_OFF:  rdata = r_count;
         default:    rdata = 32'd0;
      endcase
   end

   assign irq = r_irqFlag & r_im;

   // FSM and register file; CPU writes come last so they override the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en      <= 1'b0;
         r_mode    <= 2'b00;
         r_im      <= 1'b0;
         r_preset  <= 32'd0;
         r_count   <= 32'd0;
         r_irqFlag <= 1'b0;
         r_state   <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_en) begin
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_count <= r_preset;
               r_state <= CNT;
            end
            CNT: begin
               if (!r_en) begin
                  r_state <= IDLE;
               end else if (r_count <= 32'd1) begin
                  r_count   <= 32'd0;
                  r_irqFlag <= 1'b1;
                  r_state   <= INT;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            INT: begin
               if (r_mode == MODE_RELOAD) begin
                  r_irqFlag <= 1'b0;
                  r_state   <= LOAD;
               end else begin
                  r_en    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_ctrlWr) begin
            r_en      <= wdata[EN_BIT];
            r_mode    <= wdata[MODE_LSB +: 2];
            r_im      <= wdata[IM_BIT];
            r_irqFlag <= 1'b0;
         end
         if (w_presetWr) begin
            r_preset  <= wdata;
            r_irqFlag <= 1'b0;
         end
      end
   end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer that sits on the data-side bus as a responder to the pipelined CPU's M-stage load/store accesses. It is selected by the address bridge. It exposes three word registers (CTRL, PRESET, COUNT), counts down once per clock while enabled, and raises an interrupt request toward the CPU's exception logic. It supports one-shot and auto-reload modes.

## Interface

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- sel  input  1  chip select from bridge; access targets this block
- we  input  1  write enable; a write occurs only when sel & we
- addr  input  32  byte address; only addr[3:2] decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
- wdata  input  32  store data
- rdata  output  32  read data, combinational from addr[3:2]; independent of sel
- irq  output  1  interrupt request = irq_flag & CTRL.IM

## Operation

- CTRL register:
  - bit 0 EN
  - bits 2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00)
  - bit 3 IM
  - bits 31:4 not stored, read 0
- PRESET: 32-bit read/write.
- COUNT: 32-bit, read-only; writes to offset 2 ignored.
- Offset 3 reads 0; writes ignored.
- Writes take effect at the rising edge where sel & we.
- State machine IDLE, LOAD, CNT, INT:
  - IDLE: if EN -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - if !EN -> IDLE, COUNT holds;
    - elif COUNT <= 1 -> COUNT <= 0, -> INT, irq_flag <= 1;
    - else COUNT <= COUNT-1.
  - INT:
    - MODE 00: EN <= 0, -> IDLE; irq_flag stays 1.
    - MODE 01: -> LOAD; irq_flag <= 0 (one-cycle pulse).
- irq_flag clears on any CPU write to CTRL or PRESET, and on reset.
- State decisions use the registered CTRL value of the current cycle.

Simultaneous events:
- CPU write to CTRL in the same cycle the FSM clears EN in INT: the CPU write wins, so EN takes wdata[0]. irq_flag clears.
- CPU write to PRESET during CNT: no effect on COUNT until the next LOAD.
- CPU write clearing EN during LOAD: the LOAD completes, and CNT then exits to IDLE on the next cycle.
- PRESET = 0 or 1: LOAD -> CNT -> INT. COUNT becomes 0 on entering INT.
- Reset mid-count returns every register to 0, the state to IDLE, and irq to 0. This is the same as power-up.

## Timing

- Reset values: rdata = value of the addressed register, which is 0 for all offsets after reset. irq = 0, state IDLE, CTRL = PRESET = COUNT = 0.
- Read latency is 0 cycles (combinational), matching the M-stage load timing.
- Write latency is 1 edge.
- Edges are labelled from E0, the edge at which the CTRL write with EN=1 is made:
  - E1: LOAD.
  - E2: CNT with COUNT = PRESET.
  - Each following edge: COUNT decrements by 1.
  - E(PRESET+2): INT, and irq rises if IM=1.
  - These labels hold for PRESET >= 1.
- Auto-reload:
  - irq is high for exactly one cycle.
  - The period is PRESET+2 cycles, INT to INT.
- One-shot: irq stays high until a CPU write to CTRL or PRESET.

## Structure

- Shared package timer_pkg holds:
  - state enum (IDLE, LOAD, CNT, INT);
  - register offsets CTRL_OFF = 2'd0, PRESET_OFF = 2'd1, COUNT_OFF = 2'd2;
  - CTRL bit positions EN_BIT = 0, MODE_LSB = 1, IM_BIT = 3;
  - mode constants MODE_ONESHOT = 2'b00, MODE_RELOAD = 2'b01.
- Single module, no sub-module. The register file and FSM are too tightly coupled to split.

## Test plan

- Reset, then read offsets 0, 1, 2, 3 -> rdata = 0 for every offset; irq = 0.
- One-shot, no mask interference:
  - Stimulus: write PRESET = 3, then write CTRL = 0x9 (EN=1, MODE=00, IM=1) at edge E0.
  - Required: COUNT reads 3, 2, 1, 0 after edges E2..E5; irq rises after E5 and stays high.
  - Required: CTRL then reads 0x8. A write of CTRL = 0x8 drops irq after that edge.
- Auto-reload:
  - Stimulus: PRESET = 2, CTRL = 0xB.
  - Required: irq pulses high for 1 cycle every 4 cycles; COUNT sequence 2, 1, 0, x(LOAD), 2, ...
- Masked interrupt:
  - Stimulus: PRESET = 1, CTRL = 0x1.
  - Required: INT is reached but irq stays 0.
  - Required: a subsequent write of CTRL = 0x9 clears irq_flag, so irq stays 0.
- Mid-count events:
  - Stimulus: PRESET = 10, enable; write CTRL = 0 when COUNT = 6.
  - Required: next state IDLE; COUNT holds 5. Re-enabling reloads COUNT to 10.
  - Stimulus: separately, assert reset while COUNT = 4.
  - Required: all reads 0 and irq = 0 on the following cycle.
- Edge cases:
  - Stimulus: PRESET = 0 with one-shot enable.
  - Required: irq rises after edge E3.
  - Stimulus: write 0xFFFFFFFF to offset 2.
  - Required: COUNT unchanged.
  - Stimulus: write PRESET = 7 during CNT.
  - Required: takes effect only on the next reload.
